// File: rtl/nes_joypad.sv
// NES controller port: per-button synchronizer and debouncer feeding the
// $4016 strobe/serial-shift interface; $4017 reports an empty second port.
module nes_joypad #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  btn_raw,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        rd_hit,
  output logic [7:0]  btn_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync_a;
  logic [7:0]    sync_b;
  logic [7:0]    stable;
  logic [CW-1:0] cnt [8];

  logic          strobe;
  logic [7:0]    shift;

  logic          sel_4016;
  logic          sel_4017;
  logic          wr_4016;
  logic          rd_4016;
  logic          rd_4017;
  logic          unused_wdata;

  always_comb begin
    sel_4016 = (cpu_addr == 16'h4016);
    sel_4017 = (cpu_addr == 16'h4017);
    wr_4016  = cpu_we && sel_4016;
    // A simultaneous write wins; the read half of the cycle is dropped.
    rd_4016  = cpu_re && !cpu_we && sel_4016;
    rd_4017  = cpu_re && !cpu_we && sel_4017;
  end

  assign unused_wdata = ^cpu_wdata[7:1];
  assign btn_state    = stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 8'h00;
      sync_b <= 8'h00;
      stable <= 8'h00;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 8; i++) begin
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Strobe high keeps the shifter tracking the live buttons, including the
  // edge on which a write drops it, so the first read returns current A.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe    <= 1'b0;
      shift     <= 8'hFF;
      cpu_rdata <= 8'h00;
      rd_hit    <= 1'b0;
    end else begin
      rd_hit <= 1'b0;
      if (wr_4016) strobe <= cpu_wdata[0];

      if (strobe) begin
        shift <= stable;
      end else if (rd_4016) begin
        shift <= {1'b1, shift[7:1]};
      end

      if (rd_4016) begin
        cpu_rdata <= {7'b0100000, shift[0]};
        rd_hit    <= 1'b1;
      end else if (rd_4017) begin
        cpu_rdata <= 8'h40;
        rd_hit    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad.sv
// Randomized and directed bench for nes_joypad against a behavioural model
// that tracks debounce run lengths and a latched-byte/read-index controller.
module tb_nes_joypad;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  btn_raw = 8'h00;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        rd_hit;
  logic [7:0]  btn_state;

  int n_checks = 0;
  int n_errors = 0;

  nes_joypad #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .rd_hit    (rd_hit),
    .btn_state (btn_state)
  );

  always #5 clk = ~clk;

  // Reference model: raw delayed two cycles, a button flips after its
  // delayed value has disagreed for DC consecutive cycles; the controller
  // is a latched byte read out by index, 1s after the eighth read.
  logic [7:0] m_dl1 = 8'h00, m_dl2 = 8'h00, m_stable = 8'h00;
  int         m_run [8];
  logic       m_strobe = 1'b0;
  logic [7:0] m_latched = 8'hFF;
  int         m_idx = 0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_hit = 1'b0;
  logic [7:0] old_stable;
  logic       old_strobe;
  logic       rd_ok;
  logic       bitv;

  always @(posedge clk) begin
    if (reset) begin
      m_dl1 = 8'h00; m_dl2 = 8'h00; m_stable = 8'h00;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_strobe = 1'b0; m_latched = 8'hFF; m_idx = 0;
      m_rdata = 8'h00; m_hit = 1'b0;
    end else begin
      old_stable = m_stable;
      old_strobe = m_strobe;
      for (int i = 0; i < 8; i++) begin
        if (m_dl2[i] != old_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            m_stable[i] = m_dl2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_dl2 = m_dl1;
      m_dl1 = btn_raw;

      rd_ok = cpu_re && !cpu_we;
      m_hit = 1'b0;
      if (rd_ok && cpu_addr == 16'h4016) begin
        bitv = (m_idx < 8) ? m_latched[m_idx] : 1'b1;
        m_rdata = 8'h40 + {7'b0, bitv};
        m_hit = 1'b1;
        if (!old_strobe && m_idx < 8) m_idx = m_idx + 1;
      end else if (rd_ok && cpu_addr == 16'h4017) begin
        m_rdata = 8'h40;
        m_hit = 1'b1;
      end
      if (old_strobe) begin
        m_latched = old_stable;
        m_idx = 0;
      end
      if (cpu_we && cpu_addr == 16'h4016) m_strobe = cpu_wdata[0];
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic we, input logic re, input logic [15:0] a, input logic [7:0] d);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    check("rdata", cpu_rdata, m_rdata);
    check("rd_hit", {7'b0, rd_hit}, {7'b0, m_hit});
    check("btn_state", btn_state, m_stable);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wr16(input logic [7:0] d);
    tick(1'b1, 1'b0, 16'h4016, d);
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] exp);
    tick(1'b0, 1'b1, 16'h4016, 8'h00);
    check(tag, cpu_rdata, exp);
    check({tag, "_hit"}, {7'b0, rd_hit}, 8'h01);
  endtask

  logic [7:0] seq10 [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40,
                             8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
  logic [7:0] seq4 [4] = '{8'h41, 8'h40, 8'h40, 8'h41};

  initial begin
    int op;
    logic [15:0] a;
    @(negedge clk);
    idle(1);
    check("reset_btn_state", btn_state, 8'h00);
    check("reset_rdata", cpu_rdata, 8'h00);
    check("reset_rd_hit", {7'b0, rd_hit}, 8'h00);
    reset = 1'b0;

    rd_expect("first_read", 8'h41);

    btn_raw = 8'h09;
    idle(5);
    check("debounce_early", btn_state, 8'h00);
    idle(1);
    check("debounce_exact", btn_state, 8'h09);

    btn_raw = 8'h00;
    idle(3);
    btn_raw = 8'h09;
    idle(10);
    check("glitch_ignored", btn_state, 8'h09);

    wr16(8'h01); wr16(8'h00);
    for (int i = 0; i < 10; i++) rd_expect("read_seq", seq10[i]);

    wr16(8'h01);
    btn_raw = 8'h08;
    idle(8);
    rd_expect("strobe_live_a0", 8'h40);
    rd_expect("strobe_live_a0", 8'h40);
    btn_raw = 8'h09;
    idle(8);
    rd_expect("strobe_live_a1", 8'h41);
    rd_expect("strobe_live_a1", 8'h41);
    wr16(8'h00);
    for (int i = 0; i < 4; i++) rd_expect("after_fall", seq4[i]);

    tick(1'b0, 1'b1, 16'h4017, 8'h00);
    check("rd_4017", cpu_rdata, 8'h40);
    check("rd_4017_hit", {7'b0, rd_hit}, 8'h01);
    tick(1'b0, 1'b1, 16'h2002, 8'h00);
    check("rd_2002_hit", {7'b0, rd_hit}, 8'h00);
    check("rd_2002_hold", cpu_rdata, 8'h40);

    wr16(8'h01); wr16(8'h00);
    rd_expect("we_re_pre", 8'h41);
    tick(1'b1, 1'b1, 16'h4016, 8'h00);
    check("we_re_hit", {7'b0, rd_hit}, 8'h00);
    rd_expect("we_re_b", 8'h40);
    rd_expect("we_re_sel", 8'h40);
    rd_expect("we_re_start", 8'h41);

    wr16(8'h01); wr16(8'h00);
    for (int i = 0; i < 3; i++) rd_expect("pre_reset", seq4[i]);
    reset = 1'b1;
    idle(1);
    check("mid_reset_btn", btn_state, 8'h00);
    reset = 1'b0;
    rd_expect("post_reset_read", 8'h41);
    idle(8);
    check("post_reset_debounce", btn_state, 8'h09);
    wr16(8'h01); wr16(8'h00);
    for (int i = 0; i < 4; i++) rd_expect("reload", seq4[i]);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) btn_raw = btn_raw ^ (8'h01 << $urandom_range(0, 7));
      reset = ($urandom_range(0, 399) == 0);
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0, 1: a = 16'h4016;
        2: a = 16'h4017;
        default: a = 16'($urandom);
      endcase
      tick(op == 0 || op == 9, op >= 5, a, 8'($urandom));
    end
    reset = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nes_joypad.md
# nes_joypad

Standard NES controller port ($4016/$4017) for FPGA_NES. Sits upstream of the CPU/PPU core and takes the board push-buttons/switches as the eight controller buttons. Synchronizes and debounces each button, then presents it to the CPU bus through the NES strobe/serial-shift protocol. Also exports the debounced button vector for on-board LED/HEX debug.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 250000: stable-input cycles required before a button change is accepted (5 ms at 50 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- btn_raw  in  8  asynchronous buttons, active-high; bit order 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
- cpu_addr  in  16  CPU bus address
- cpu_we  in  1  CPU write strobe, one cycle per access
- cpu_re  in  1  CPU read strobe, one cycle per access
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  registered read data
- rd_hit  out  1  high for one cycle when cpu_rdata carries a response from this block
- btn_state  out  8  debounced button vector, same bit order as btn_raw

## Operation
- Reset state (every output and register): sync flops 0, debounced state 0, debounce counters 0, strobe 0, shift register 8'hFF, cpu_rdata 8'h00, rd_hit 0, btn_state 8'h00.
- Synchronizer: two flops per bit, btn_raw → sync.
- Debounce, per bit independently:
  - sync == stable: counter cleared to 0.
  - Otherwise: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter <= 0.
  - Counter width: $clog2(DEBOUNCE_CYCLES); counter never wraps.
- btn_state = stable vector (registered).
- Write $4016 (cpu_we, cpu_addr==16'h4016): strobe <= cpu_wdata[0]; cpu_wdata[7:1] ignored.
- While strobe==1: shift register reloaded from stable every cycle, including the cycle strobe falls.
  - Load on the falling-strobe cycle uses stable as of that cycle.
- Read $4016 (cpu_re, addr 16'h4016):
  - cpu_rdata <= 8'h40 | {7'b0, shift[0]}; rd_hit <= 1.
  - If strobe==0: shift <= {1'b1, shift[7:1]}.
  - If strobe==1: no shift; reads repeat the live A button.
  - After 8 reads with strobe 0, every further read returns 8'h41.
- Read $4017 (controller 2 not fitted): cpu_rdata <= 8'h40, rd_hit <= 1; no state change.
- Write $4017: ignored by this block (APU frame counter).
- Access to any other address: cpu_rdata holds its value, rd_hit <= 0.
- cpu_we and cpu_re asserted in the same cycle: write is performed, read is ignored (no shift, rd_hit 0).

## Timing
- btn_raw edge → stable/btn_state change: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles: no change.
- Read: cpu_re at cycle N → cpu_rdata/rd_hit valid at N+1; rd_hit returns to 0 at N+2 unless another read occurs.
- Back-to-back reads on consecutive cycles: supported, one shift per read.
- Write → strobe updated at N+1; a read at N+1 sees the new strobe.
- Reset asserted mid-sequence: all state returns to reset values on the next edge. The first read after reset with strobe 0 returns 8'h41 (shift 8'hFF).

## Test plan
- Reset, then read $4016 with no strobe → cpu_rdata 8'h41, rd_hit 1 one cycle later.
- DEBOUNCE_CYCLES=4; btn_raw=8'h09 (A+Start) held steady → btn_state 8'h09 exactly 6 cycles after the change. A 3-cycle glitch to 8'h00 → btn_state unchanged.
- btn_state 8'h09; write 1 then 0 to $4016; 10 reads → 41,40,40,41,40,40,40,40,41,41.
- Strobe held at 1, btn A toggled and debounced; repeated reads track A (41/40) with no shift. After strobe falls, the sequence starts from A.
- Read $4017 → 8'h40, rd_hit 1. Read $2002 → rd_hit 0, cpu_rdata unchanged. Simultaneous we+re at $4016 → strobe updated, no shift, rd_hit 0.
- Reset pulsed after 3 of 8 reads → btn_state 0, next read returns 8'h41. Re-strobe then reloads correctly after debounce completes.
